// File: rtl/shared_timer_sched.sv
// rtl/shared_timer_sched.sv - round-robin scheduler sharing one up-counter timer among requesters
module shared_timer_sched #(
    parameter int N_REQ = 4,
    parameter int CW    = 4
) (
    input  logic                Clk,
    input  logic                aResetn,
    input  logic                Tick,
    input  logic [N_REQ-1:0]    Req,
    input  logic [N_REQ*CW-1:0] MaxCnt,
    output logic [N_REQ-1:0]    Grant,
    output logic                Busy,
    output logic [CW-1:0]       Count,
    output logic [N_REQ-1:0]    Done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state;
    logic [IW-1:0]      last;
    logic [IW-1:0]      win;
    logic [CW-1:0]      max_r;
    logic [CW-1:0]      count;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic               busy;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;
    logic               win_req;
    logic [CW-1:0]      win_max;

    // Round-robin pick: scan from last+1 upward; iterating backwards lets the nearest hit win
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = N_REQ; off >= 1; off--) begin
            cand = IW'((int'(last) + off) % N_REQ);
            if (Req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Select the current owner's request level and terminal count
    always_comb begin
        win_req = 1'b0;
        win_max = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == IW'(i)) begin
                win_req = Req[i];
                win_max = MaxCnt[i*CW +: CW];
            end
        end
    end

    // Scheduler FSM with registered outputs; abort (owner drops Req) beats expiry
    always_ff @(posedge Clk or negedge aResetn) begin
        if (!aResetn) begin
            state <= S_IDLE;
            last  <= IW'(N_REQ - 1);
            win   <= '0;
            max_r <= '0;
            count <= '0;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done  <= '0;
                    count <= '0;
                    if (pick_valid) begin
                        state <= S_LOAD;
                        win   <= pick_idx;
                        last  <= pick_idx;
                        grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        busy  <= 1'b1;
                    end else begin
                        grant <= '0;
                        busy  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!win_req) begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else begin
                        max_r <= win_max;
                        count <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!win_req) begin
                        state <= S_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                    end else if (Tick) begin
                        if (count == max_r) begin
                            state <= S_DONE;
                            done  <= grant;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= '0;
                    grant <= '0;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

    assign Grant = grant;
    assign Busy  = busy;
    assign Count = count;
    assign Done  = done;

endmodule

// File: tb/tb_shared_timer_sched.sv
// tb/tb_shared_timer_sched.sv - self-checking bench for shared_timer_sched
module tb_shared_timer_sched;

    localparam int N  = 4;
    localparam int CW = 4;

    logic            Clk;
    logic            aResetn;
    logic            Tick;
    logic [N-1:0]    Req;
    logic [N*CW-1:0] MaxCnt;
    logic [N-1:0]    Grant;
    logic            Busy;
    logic [CW-1:0]   Count;
    logic [N-1:0]    Done;

    int n_cmp;
    int n_bad;

    shared_timer_sched #(.N_REQ(N), .CW(CW)) dut (
        .Clk    (Clk),
        .aResetn(aResetn),
        .Tick   (Tick),
        .Req    (Req),
        .MaxCnt (MaxCnt),
        .Grant  (Grant),
        .Busy   (Busy),
        .Count  (Count),
        .Done   (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [N-1:0]    req;
        logic            tick;
        logic [N*CW-1:0] maxcnt;
        logic [N-1:0]    g;
        logic            b;
        logic [CW-1:0]   c;
        logic [N-1:0]    d;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [N-1:0] req, logic tick, logic [N*CW-1:0] mc,
                                logic [N-1:0] g, logic b, logic [CW-1:0] c, logic [N-1:0] d);
        vec_t v;
        v.req = req; v.tick = tick; v.maxcnt = mc;
        v.g = g; v.b = b; v.c = c; v.d = d;
        return v;
    endfunction

    function automatic int outs();
        return int'({Grant, Busy, Count, Done});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        aResetn = 1'b0;
        Req     = '0;
        Tick    = 1'b0;
        MaxCnt  = '0;
        repeat (2) @(posedge Clk);
        #1 aResetn = 1'b1;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Behavioural reference: tracks owner and ticks consumed, not the RTL's states
    int m_owner, m_last, m_ticks, m_lim;
    bit m_load, m_fin;

    task automatic model_reset();
        m_owner = -1; m_last = N - 1; m_ticks = 0; m_lim = 0;
        m_load = 0; m_fin = 0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic t, input logic [N*CW-1:0] mc);
        if (m_fin) begin
            m_fin = 0; m_owner = -1; m_ticks = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (r[c]) begin
                    m_owner = c; m_last = c; m_ticks = 0; m_load = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_owner = -1; m_ticks = 0; m_load = 0;
        end else if (m_load) begin
            m_lim  = int'((mc >> (m_owner * CW)) & {{(N*CW-CW){1'b0}}, {CW{1'b1}}});
            m_load = 0;
        end else if (t) begin
            if (m_ticks == m_lim) m_fin = 1;
            else m_ticks++;
        end
    endtask

    function automatic int model_outs();
        logic [N-1:0]  g;
        logic          b;
        logic [CW-1:0] c;
        logic [N-1:0]  d;
        g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        b = (m_owner >= 0);
        c = (m_owner >= 0) ? CW'(m_ticks) : '0;
        d = m_fin ? g : '0;
        return int'({g, b, c, d});
    endfunction

    initial begin
        int exp_rr[5];
        logic [N-1:0] gseen;
        bit seen_done, okc;
        int nt;
        logic [N-1:0] r;
        logic t;
        logic [N*CW-1:0] mc;

        n_cmp = 0;
        n_bad = 0;

        // Reset state
        aResetn = 1'b0; Req = '0; Tick = 1'b0; MaxCnt = '0;
        #12;
        chk("reset outputs", outs(), 0);

        // Table: single requester run, MaxCnt changes ignored after LOAD, max=0, round robin
        tbl.push_back(mk(4'b0010, 1, 16'hF03F, 4'b0010, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0010, 1, 16'hF03F, 4'b0010, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0010, 1, 16'h0000, 4'b0010, 1, 1, 4'b0000));
        tbl.push_back(mk(4'b0010, 1, 16'h0000, 4'b0010, 1, 2, 4'b0000));
        tbl.push_back(mk(4'b0010, 1, 16'h0000, 4'b0010, 1, 3, 4'b0000));
        tbl.push_back(mk(4'b0010, 1, 16'h0000, 4'b0010, 1, 3, 4'b0010));
        tbl.push_back(mk(4'b0000, 1, 16'h0000, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(4'b0000, 1, 16'h0000, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(4'b1000, 1, 16'h0FFF, 4'b1000, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b1000, 1, 16'h0FFF, 4'b1000, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b1000, 1, 16'h0FFF, 4'b1000, 1, 0, 4'b1000));
        tbl.push_back(mk(4'b0000, 1, 16'h0FFF, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(4'b0011, 0, 16'h0000, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0011, 0, 16'h0000, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0011, 0, 16'h0000, 4'b0001, 1, 0, 4'b0000));
        tbl.push_back(mk(4'b0011, 1, 16'h0000, 4'b0001, 1, 0, 4'b0001));
        tbl.push_back(mk(4'b0011, 0, 16'h0000, 4'b0000, 0, 0, 4'b0000));
        tbl.push_back(mk(4'b0011, 0, 16'h0000, 4'b0010, 1, 0, 4'b0000));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            Req = tbl[i].req; Tick = tbl[i].tick; MaxCnt = tbl[i].maxcnt;
            step();
            chk($sformatf("table row %0d", i), outs(),
                int'({tbl[i].g, tbl[i].b, tbl[i].c, tbl[i].d}));
        end

        // All requesters held: round-robin order, each Done matches its Grant
        do_reset();
        Req = 4'b1111; MaxCnt = 16'h1111; Tick = 1'b1;
        exp_rr = '{1, 2, 4, 8, 1};
        for (int g = 0; g < 5; g++) begin
            for (int cyc = 0; cyc < 30; cyc++) begin
                step();
                if (Grant != 0) break;
            end
            chk($sformatf("rr grant %0d", g), int'(Grant), exp_rr[g]);
            gseen = Grant;
            for (int cyc = 0; cyc < 30; cyc++) begin
                step();
                if (Done != 0) break;
            end
            chk($sformatf("rr done %0d", g), int'(Done), int'(gseen));
        end

        // Abort at Count=4, no Done, regrant afterwards
        do_reset();
        Req = 4'b0100; MaxCnt = 16'h0900; Tick = 1'b1;
        seen_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (Done != 0) seen_done = 1;
            if (Count == 4) break;
        end
        chk("abort reach count 4", int'(Count), 4);
        Req = 4'b0000;
        step();
        if (Done != 0) seen_done = 1;
        chk("abort idle outputs", outs(), 0);
        step();
        if (Done != 0) seen_done = 1;
        chk("abort no done", int'(seen_done), 0);
        Req = 4'b0100;
        step();
        chk("abort regrant", int'(Grant), 4'b0100);

        // Abort wins over expiry in the same cycle
        do_reset();
        Req = 4'b0010; MaxCnt = 16'h0000; Tick = 1'b1;
        step();
        step();
        Req = 4'b0000;
        step();
        chk("abort beats expiry", outs(), 0);

        // Tick every third cycle: Count follows ticks, Done after 3 ticks
        do_reset();
        Req = 4'b0001; MaxCnt = 16'h0002; Tick = 1'b0;
        step();
        step();
        nt = 0; okc = 1; seen_done = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            Tick = (cyc % 3 == 2);
            step();
            if (Tick) nt++;
            if (Done != 0) begin
                seen_done = 1;
                chk("slow tick done value", int'(Done), 1);
                break;
            end
            if (int'(Count) != nt) okc = 0;
        end
        Tick = 1'b0;
        chk("slow tick count tracks ticks", int'(okc), 1);
        chk("slow tick done seen", int'(seen_done), 1);
        chk("slow tick ticks to done", nt, 3);

        // Asynchronous reset mid-run, then round-robin restarts at requester 0
        do_reset();
        Req = 4'b0100; MaxCnt = 16'h0900; Tick = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            step();
            if (Count == 5) break;
        end
        chk("async pre count", int'(Count), 5);
        chk("async pre grant", int'(Grant), 4'b0100);
        Req = 4'b0101;
        #2 aResetn = 1'b0;
        #1;
        chk("async reset outputs", outs(), 0);
        #2 aResetn = 1'b1;
        step();
        chk("post reset grant", int'(Grant), 4'b0001);

        // Randomised run against the reference model
        do_reset();
        model_reset();
        r = '0; t = 1'b0; mc = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (r[i]) begin
                    if ($urandom_range(0, 19) == 0) r[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[i] = 1'b1;
                end
            end
            t  = ($urandom_range(0, 1) == 1);
            mc = N*CW'($urandom);
            Req = r; Tick = t; MaxCnt = mc;
            @(posedge Clk);
            model_step(r, t, mc);
            #1;
            chk($sformatf("random cycle %0d", cyc), outs(), model_outs());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
